add_seq_n_bit: RTL and testbench

ADD_SEQ_N_BIT -- requirements
Module: add_seq_n_bit

---
 rtl/add_seq_n_bit_pkg.sv | 19 +
 rtl/add_seq_n_bit_rca.sv | 21 ++
 rtl/add_seq_n_bit.sv | 108 ++++++++++
 tb/tb_add_seq_n_bit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/add_seq_n_bit_pkg.sv
// rtl/add_seq_n_bit_pkg.sv - shared FSM encodings and chunk-count helpers for the sequential adder
package add_seq_n_bit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a one-bit index register.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/add_seq_n_bit_rca.sv
// rtl/add_seq_n_bit_rca.sv - combinational N-bit adder slice with carry into the MSB
module add_rca_n_bit #(
    parameter int N = 8
) (
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    input  logic         ci,
    output logic [N-1:0] sum,
    output logic         co,
    output logic         c_msb
);

    logic [N:0] full;

    assign full  = {1'b0, X} + {1'b0, Y} + {{N{1'b0}}, ci};
    assign sum   = full[N-1:0];
    assign co    = full[N];
    // The MSB sum bit is X^Y^carry_in, so the incoming carry can be recovered from it.
    assign c_msb = full[N-1] ^ X[N-1] ^ Y[N-1];

endmodule

// File: rtl/add_seq_n_bit.sv
// rtl/add_seq_n_bit.sv - multi-cycle adder/subtractor processing CHUNK bits per clock
module add_seq_n_bit
    import add_seq_n_bit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             overflow
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IDXW   = idx_width(NCHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    state_t            state;
    state_t            next_state;
    logic [WIDTH-1:0]  x_r;
    logic [WIDTH-1:0]  y_r;
    logic              carry;
    logic [IDXW-1:0]   idx;
    int                off;
    logic [CHUNK-1:0]  rca_sum;
    logic              rca_co;
    logic              rca_cmsb;

    assign off = int'(idx) * CHUNK;

    add_rca_n_bit #(.N(CHUNK)) u_rca (
        .X     (x_r[off +: CHUNK]),
        .Y     (y_r[off +: CHUNK]),
        .ci    (carry),
        .sum   (rca_sum),
        .co    (rca_co),
        .c_msb (rca_cmsb)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = ST_RUN;
            end
            ST_RUN: begin
                if (idx == LAST_IDX) next_state = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Subtraction is X + ~Y + 1, so the inversion and the +1 are folded in at accept time.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r      <= '0;
            y_r      <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            sum      <= '0;
            co       <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_r   <= X;
                        y_r   <= sub ? ~Y : Y;
                        carry <= sub ? 1'b1 : ci;
                        idx   <= '0;
                    end
                end
                ST_RUN: begin
                    sum[off +: CHUNK] <= rca_sum;
                    carry             <= rca_co;
                    idx               <= idx + IDXW'(1);
                    if (idx == LAST_IDX) begin
                        co       <= rca_co;
                        overflow <= rca_cmsb ^ rca_co;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_add_seq_n_bit.sv
// tb/tb_add_seq_n_bit.sv - randomized self-checking bench for add_seq_n_bit across four configurations
module tb_add_seq_n_bit;

    localparam int W[4]  = '{32, 32, 32, 16};
    localparam int NC[4] = '{4, 32, 1, 4};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst[4], in_valid[4], ci[4], sub[4], out_ready[4];
    logic [31:0] xa[4], ya[4];
    logic        in_ready[4], out_valid[4], co[4], ovf[4];
    logic [31:0] s0, s1, s2;
    logic [15:0] s3;
    logic [31:0] sa[4];

    assign sa[0] = s0;
    assign sa[1] = s1;
    assign sa[2] = s2;
    assign sa[3] = {16'd0, s3};

    add_seq_n_bit #(.WIDTH(32), .CHUNK(8)) u0 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .X(xa[0]), .Y(ya[0]), .ci(ci[0]), .sub(sub[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .sum(s0), .co(co[0]), .overflow(ovf[0]));
    add_seq_n_bit #(.WIDTH(32), .CHUNK(1)) u1 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .X(xa[1]), .Y(ya[1]), .ci(ci[1]), .sub(sub[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .sum(s1), .co(co[1]), .overflow(ovf[1]));
    add_seq_n_bit #(.WIDTH(32), .CHUNK(32)) u2 (
        .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .X(xa[2]), .Y(ya[2]), .ci(ci[2]), .sub(sub[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .sum(s2), .co(co[2]), .overflow(ovf[2]));
    add_seq_n_bit #(.WIDTH(16), .CHUNK(4)) u3 (
        .clk(clk), .rst(rst[3]), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .X(xa[3][15:0]), .Y(ya[3][15:0]), .ci(ci[3]), .sub(sub[3]), .out_valid(out_valid[3]),
        .out_ready(out_ready[3]), .sum(s3), .co(co[3]), .overflow(ovf[3]));

    int     checks;
    int     errors;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit     pend[4], seen[4], rst_prev[4];
    longint acc[4], e_sum[4];
    bit     e_co[4], e_ov[4];

    function automatic void chk(input string name, input int k, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got=%0h exp=%0h", name, k, got, exp);
        end
    endfunction

    // Reference: plain unsigned and signed integer arithmetic on the operands.
    function automatic void model(input int w, input longint x, input longint y, input bit c, input bit s,
                                  output longint rs, output bit rco, output bit rov);
        longint m, half, sx, sy, r;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        sx   = (x >= half) ? x - (m + 1) : x;
        sy   = (y >= half) ? y - (m + 1) : y;
        if (s) begin
            rs  = (x - y) & m;
            rco = (x >= y);
            r   = sx - sy;
        end else begin
            rs  = (x + y + longint'(c)) & m;
            rco = (x + y + longint'(c)) > m;
            r   = sx + sy + longint'(c);
        end
        rov = (r >= half) || (r < -half);
    endfunction

    task automatic monitor();
        longint m;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                m = (longint'(1) << W[k]) - 1;
                if (rst[k]) begin
                    pend[k]     = 1'b0;
                    rst_prev[k] = 1'b1;
                end else begin
                    if (rst_prev[k]) begin
                        chk("rst_sum", k, sa[k], 0);
                        chk("rst_co", k, co[k], 0);
                        chk("rst_ovf", k, ovf[k], 0);
                        rst_prev[k] = 1'b0;
                    end
                    if (!pend[k]) begin
                        chk("idle_in_ready", k, in_ready[k], 1);
                        chk("idle_out_valid", k, out_valid[k], 0);
                        if (in_valid[k]) begin
                            model(W[k], longint'(xa[k]) & m, longint'(ya[k]) & m, ci[k], sub[k],
                                  e_sum[k], e_co[k], e_ov[k]);
                            pend[k] = 1'b1;
                            seen[k] = 1'b0;
                            acc[k]  = cyc + 1;
                        end
                    end else if (!out_valid[k]) begin
                        chk("busy_in_ready", k, in_ready[k], 0);
                    end else begin
                        if (!seen[k]) begin
                            chk("latency", k, cyc - acc[k], NC[k]);
                            seen[k] = 1'b1;
                        end
                        chk("done_in_ready", k, in_ready[k], 0);
                        chk("sum", k, sa[k], e_sum[k]);
                        chk("co", k, co[k], e_co[k]);
                        chk("overflow", k, ovf[k], e_ov[k]);
                        if (out_ready[k]) pend[k] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic op(input int k, input longint x, input longint y, input bit c, input bit s,
                      input int hold, input bit toggle, input int rst_after,
                      input bit lit, input longint lsum, input bit lco, input bit lov);
        int n;
        xa[k] = 32'(x); ya[k] = 32'(y); ci[k] = c; sub[k] = s;
        in_valid[k] = 1'b1; out_ready[k] = 1'b0;
        n = 0;
        while (!in_ready[k] && n < 200) begin @(posedge clk); #1; n++; end
        chk("accept_wait", k, in_ready[k], 1);
        if (!in_ready[k]) begin in_valid[k] = 1'b0; return; end
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        xa[k] = $urandom; ya[k] = $urandom; ci[k] = 1'($urandom); sub[k] = 1'($urandom);
        if (rst_after >= 0) begin
            repeat (rst_after) begin @(posedge clk); #1; end
            rst[k] = 1'b1;
            @(posedge clk); #1;
            rst[k] = 1'b0;
            return;
        end
        n = 0;
        while (!out_valid[k] && n < 200) begin @(posedge clk); #1; n++; end
        chk("done_wait", k, out_valid[k], 1);
        if (!out_valid[k]) return;
        if (lit) begin
            chk("lit_sum", k, sa[k], lsum);
            chk("lit_co", k, co[k], lco);
            chk("lit_ovf", k, ovf[k], lov);
        end
        repeat (hold) begin
            if (toggle) begin in_valid[k] = 1'($urandom); xa[k] = $urandom; end
            @(posedge clk); #1;
        end
        in_valid[k] = 1'b0; out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
    endtask

    function automatic longint pick(input int w);
        longint m;
        m = (longint'(1) << w) - 1;
        case ($urandom_range(0, 7))
            0: return 0;
            1: return m;
            2: return longint'(1) << (w - 1);
            3: return (longint'(1) << (w - 1)) - 1;
            default: return longint'($urandom) & m;
        endcase
    endfunction

    task automatic sweep(input int k);
        for (int i = 0; i < 1000; i++)
            op(k, pick(W[k]), pick(W[k]), 1'($urandom), 1'($urandom),
               int'($urandom_range(0, 2)), k == 0, -1, 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int k = 0; k < 4; k++) begin
            rst[k] = 1'b1; in_valid[k] = 1'b0; out_ready[k] = 1'b0;
            ci[k] = 1'b0; sub[k] = 1'b0; xa[k] = '0; ya[k] = '0;
            pend[k] = 1'b0; seen[k] = 1'b0; rst_prev[k] = 1'b0;
        end
        fork monitor(); join_none
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) rst[k] = 1'b0;

        op(0, 64'hFFFFFFFF, 0, 1'b1, 1'b0, 0, 1'b0, -1, 1'b1, 0, 1'b1, 1'b0);
        op(0, 64'h7FFFFFFF, 1, 1'b0, 1'b0, 0, 1'b0, -1, 1'b1, 64'h80000000, 1'b0, 1'b1);
        op(0, 5, 7, 1'b0, 1'b1, 0, 1'b0, -1, 1'b1, 64'hFFFFFFFE, 1'b0, 1'b0);
        op(0, 64'h80000000, 1, 1'b0, 1'b1, 0, 1'b0, -1, 1'b1, 64'h7FFFFFFF, 1'b1, 1'b1);
        op(0, 64'h0000FFFF, 1, 1'b0, 1'b0, 10, 1'b1, -1, 1'b1, 64'h00010000, 1'b0, 1'b0);
        op(0, 3, 4, 1'b1, 1'b0, 0, 1'b0, -1, 1'b1, 8, 1'b0, 1'b0);
        op(0, 64'h12345678, 1, 1'b0, 1'b0, 0, 1'b0, 2, 1'b0, 0, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;

        fork
            sweep(0);
            sweep(1);
            sweep(2);
            sweep(3);
        join
        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
